uart_tx_serializer: RTL and testbench

Transmit-side serial engine for the UART 16750 core; the counterpart of the receive path.
- Accepts one parallel character from the TX FIFO/THR logic via a start strobe.
- Serializes it LSB-first on SOUT with start, 5-8 data, optional parity and 1/1.5/2 stop bits, all timed by the 16x baud enable TXCLK.
- Reports completion to the line-status/interrupt logic (THRE/TEMT).

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_serializer_counter.sv | 29 ++
 rtl/uart_tx_serializer.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Holds the transmitter state encoding and the word-length decode.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        STOP2
    } tx_state_t;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    function automatic logic [3:0] data_bits(input logic [1:0] wls);
        return 4'd5 + {2'b00, wls};
    endfunction

    // Selects the character bits that take part in the parity calculation.
    function automatic logic [7:0] data_mask(input logic [1:0] wls);
        case (wls)
            WLS_5:   return 8'h1F;
            WLS_6:   return 8'h3F;
            WLS_7:   return 8'h7F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_serializer_counter.sv
// Free-running wrap-around counter used as the baud-tick divider.
// OVERFLOW is combinational: high on the enable that wraps the count.
module slib_counter #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count,
    output logic             o_overflow
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count    = r_count;
    assign o_overflow = i_enable && (r_count == {WIDTH{1'b1}});

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, 5-8 data bits LSB first, optional parity,
// 1/1.5/2 stop bits, all paced by the oversampled baud enable TXCLK.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TXCLK,
    input  logic       TXSTART,
    input  logic       CLEAR,
    input  logic [7:0] DIN,
    input  logic [1:0] WLS,
    input  logic       STB,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       SP,
    input  logic       BC,
    output logic       SOUT,
    output logic       BUSY,
    output logic       TXFINISHED
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);

    tx_state_t    r_state;
    logic [7:0]   r_shift;
    logic [2:0]   r_bitcnt;
    logic [1:0]   r_wls;
    logic         r_stb;
    logic         r_pen;
    logic         r_par;
    logic         r_sout;
    logic         r_busy;
    logic         r_fin;

    logic          w_accept;
    logic          w_cnt_clr;
    logic [CW-1:0] w_cnt;
    logic          w_tick;
    logic          w_half_tick;
    logic          w_last_bit;
    logic          w_din_par;
    logic          w_par_bit;
    logic          w_stop2_done;
    logic          w_line_nxt;

    assign w_accept  = (r_state == IDLE) && TXSTART && !CLEAR;
    assign w_cnt_clr = w_accept | CLEAR;

    slib_counter #(
        .WIDTH(CW)
    ) u_baud (
        .CLK       (CLK),
        .RST       (RST),
        .i_clear   (w_cnt_clr),
        .i_enable  (TXCLK),
        .o_count   (w_cnt),
        .o_overflow(w_tick)
    );

    assign w_half_tick  = TXCLK && (w_cnt == HALF_LAST);
    assign w_last_bit   = ({1'b0, r_bitcnt} == (data_bits(r_wls) - 4'd1));
    assign w_stop2_done = (r_wls == WLS_5) ? w_half_tick : w_tick;

    // Parity is resolved at acceptance so only one bit has to be held.
    assign w_din_par = ^(DIN & data_mask(WLS));
    assign w_par_bit = SP ? ~EPS : (EPS ? w_din_par : ~w_din_par);

    // Undistorted line level for the next cycle; BC is applied on top.
    always_comb begin
        w_line_nxt = 1'b1;
        if (!CLEAR) begin
            case (r_state)
                IDLE:    w_line_nxt = ~TXSTART;
                START:   w_line_nxt = w_tick ? r_shift[0] : 1'b0;
                DATA: begin
                    if (!w_tick)
                        w_line_nxt = r_shift[0];
                    else if (!w_last_bit)
                        w_line_nxt = r_shift[1];
                    else
                        w_line_nxt = r_pen ? r_par : 1'b1;
                end
                PAR:     w_line_nxt = w_tick ? 1'b1 : r_par;
                default: w_line_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_wls    <= WLS_5;
            r_stb    <= 1'b0;
            r_pen    <= 1'b0;
            r_par    <= 1'b0;
            r_sout   <= 1'b1;
            r_busy   <= 1'b0;
            r_fin    <= 1'b0;
        end else begin
            r_fin  <= 1'b0;
            r_sout <= w_line_nxt & ~BC;
            if (CLEAR) begin
                r_state  <= IDLE;
                r_bitcnt <= '0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (TXSTART) begin
                            r_state  <= START;
                            r_shift  <= DIN;
                            r_wls    <= WLS;
                            r_stb    <= STB;
                            r_pen    <= PEN;
                            r_par    <= w_par_bit;
                            r_bitcnt <= '0;
                            r_busy   <= 1'b1;
                        end
                    end
                    START: begin
                        if (w_tick) r_state <= DATA;
                    end
                    DATA: begin
                        if (w_tick) begin
                            if (w_last_bit) begin
                                r_bitcnt <= '0;
                                r_state  <= r_pen ? PAR : STOP;
                            end else begin
                                r_bitcnt <= r_bitcnt + 3'd1;
                                r_shift  <= {1'b0, r_shift[7:1]};
                            end
                        end
                    end
                    PAR: begin
                        if (w_tick) r_state <= STOP;
                    end
                    STOP: begin
                        if (w_tick) begin
                            if (r_stb) begin
                                r_state <= STOP2;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                r_fin   <= 1'b1;
                            end
                        end
                    end
                    STOP2: begin
                        if (w_stop2_done) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_fin   <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SOUT       = r_sout;
    assign BUSY       = r_busy;
    assign TXFINISHED = r_fin;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: expected line segments are queued
// when a frame is launched and consumed cycle by cycle as SOUT is observed.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

    logic       CLK = 1'b0;
    logic       RST, TXSTART, CLEAR, STB, PEN, EPS, SP, BC;
    logic [7:0] DIN;
    logic [1:0] WLS;
    logic       TXCLK;
    logic       SOUT, BUSY, TXFINISHED;

    int div     = 1;
    int div_cnt = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic lvl;
        int   len;
    } seg_t;
    seg_t sb[$];

    uart_tx_serializer #(.OVERSAMPLE(16)) dut (
        .CLK(CLK), .RST(RST), .TXCLK(TXCLK), .TXSTART(TXSTART), .CLEAR(CLEAR),
        .DIN(DIN), .WLS(WLS), .STB(STB), .PEN(PEN), .EPS(EPS), .SP(SP), .BC(BC),
        .SOUT(SOUT), .BUSY(BUSY), .TXFINISHED(TXFINISHED)
    );

    always #5 CLK = ~CLK;

    // Baud enable: one pulse every 'div' clocks.
    always @(posedge CLK) div_cnt <= (div_cnt >= div - 1) ? 0 : div_cnt + 1;
    assign TXCLK = (div_cnt == 0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_seg(input logic lvl, input int len);
        seg_t s;
        s.lvl = lvl;
        s.len = len;
        sb.push_back(s);
    endtask

    task automatic push_frame(input logic [7:0] din, input logic [1:0] wls, input logic stb,
                              input logic pen, input logic eps, input logic sp);
        int   nb;
        int   bt;
        int   ones;
        logic par;
        nb   = 5 + int'(wls);
        bt   = 16 * div;
        ones = 0;
        push_seg(1'b0, bt);
        for (int i = 0; i < nb; i++) begin
            push_seg(din[i], bt);
            ones += int'(din[i]);
        end
        if (pen) begin
            if (sp) par = ~eps;
            else    par = eps ? ones[0] : ~ones[0];
            push_seg(par, bt);
        end
        push_seg(1'b1, bt);
        if (stb) push_seg(1'b1, (wls == 2'b00) ? bt / 2 : bt);
    endtask

    // Called at a negedge; returns at the negedge of the first frame cycle.
    task automatic start_frame(input logic [7:0] din, input logic [1:0] wls, input logic stb,
                               input logic pen, input logic eps, input logic sp, input bit hold);
        DIN = din; WLS = wls; STB = stb; PEN = pen; EPS = eps; SP = sp;
        while (TXCLK !== 1'b1) @(negedge CLK);
        TXSTART = 1'b1;
        @(negedge CLK);
        if (!hold) TXSTART = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        seg_t s;
        int   bad;
        int   idx;
        bit   busy_ok;
        bit   fin_ok;
        idx     = 0;
        busy_ok = 1'b1;
        fin_ok  = 1'b1;
        while (sb.size() > 0) begin
            s   = sb.pop_front();
            bad = 0;
            for (int c = 0; c < s.len; c++) begin
                if (SOUT !== s.lvl) bad++;
                if (BUSY !== 1'b1) busy_ok = 1'b0;
                if (TXFINISHED !== 1'b0) fin_ok = 1'b0;
                @(negedge CLK);
            end
            chk($sformatf("%s seg%0d bad_cycles", tag, idx), bad, 0);
            idx++;
        end
        chk({tag, " busy_in_frame"}, 32'(busy_ok), 1);
        chk({tag, " no_early_fin"}, 32'(fin_ok), 1);
        chk({tag, " fin_pulse"}, 32'(TXFINISHED), 1);
        chk({tag, " busy_end"}, 32'(BUSY), 0);
        chk({tag, " sout_end"}, 32'(SOUT), 1);
    endtask

    task automatic watch_idle(input string tag, input int cycles);
        bit ok;
        ok = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            if (TXFINISHED !== 1'b0 || BUSY !== 1'b0 || SOUT !== 1'b1) ok = 1'b0;
            @(negedge CLK);
        end
        chk({tag, " quiet_idle"}, 32'(ok), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic eps_v[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic sp_v[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        RST = 1'b1; TXSTART = 1'b0; CLEAR = 1'b0; BC = 1'b0;
        DIN = 8'h00; WLS = 2'b00; STB = 1'b0; PEN = 1'b0; EPS = 1'b0; SP = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset sout", 32'(SOUT), 1);
        chk("reset busy", 32'(BUSY), 0);
        chk("reset fin", 32'(TXFINISHED), 0);
        RST = 1'b0;
        @(negedge CLK);

        // 8N1 0x55 at full baud rate
        push_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        start_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("8N1_55");
        @(negedge CLK);
        chk("8N1_55 fin_single", 32'(TXFINISHED), 0);

        // 7-bit parity variants on 0x83
        for (int v = 0; v < 4; v++) begin
            push_frame(8'h83, 2'b10, 1'b0, 1'b1, eps_v[v], sp_v[v]);
            start_frame(8'h83, 2'b10, 1'b0, 1'b1, eps_v[v], sp_v[v], 1'b0);
            check_frame($sformatf("7P1_83_v%0d", v));
        end

        // Long stop variants, then quarter-rate baud
        push_frame(8'hFF, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        start_frame(8'hFF, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("5N1.5_FF");
        push_frame(8'h96, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        start_frame(8'h96, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("8N2_96");
        div = 4;
        push_frame(8'hFF, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        start_frame(8'hFF, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("5N1.5_FF_div4");
        div = 1;
        @(negedge CLK);

        // Back-to-back with TXSTART held; config changed mid-frame
        push_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        start_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        DIN = 8'h3C;
        check_frame("b2b_A5");
        push_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        TXSTART = 1'b0;
        check_frame("b2b_3C");

        // TXSTART pulse and config change mid-frame are ignored
        push_frame(8'h0F, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        start_frame(8'h0F, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        fork
            check_frame("midstart_0F");
            begin
                repeat (40) @(negedge CLK);
                TXSTART = 1'b1; WLS = 2'b00; PEN = 1'b0; STB = 1'b1;
                @(negedge CLK);
                TXSTART = 1'b0;
            end
        join
        @(negedge CLK);
        watch_idle("midstart", 20);

        // Break during DATA of 0xFF
        push_seg(1'b0, 16); push_seg(1'b1, 17); push_seg(1'b0, 32); push_seg(1'b1, 95);
        start_frame(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        fork
            check_frame("break_data");
            begin
                repeat (32) @(negedge CLK);
                BC = 1'b1;
                repeat (32) @(negedge CLK);
                BC = 1'b0;
            end
        join
        @(negedge CLK);

        // Break in IDLE
        BC = 1'b1;
        @(negedge CLK);
        chk("break_idle sout", 32'(SOUT), 0);
        chk("break_idle busy", 32'(BUSY), 0);
        BC = 1'b0;
        @(negedge CLK);
        chk("break_idle release", 32'(SOUT), 1);

        // CLEAR during the parity bit (7E1 0x83 -> parity 0)
        start_frame(8'h83, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (134) @(negedge CLK);
        chk("clear par_bit", 32'(SOUT), 0);
        chk("clear busy_before", 32'(BUSY), 1);
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        chk("clear sout", 32'(SOUT), 1);
        chk("clear busy", 32'(BUSY), 0);
        chk("clear fin", 32'(TXFINISHED), 0);
        watch_idle("after_clear", 40);
        push_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        start_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("post_clear_5A");

        // Asynchronous reset during DATA
        start_frame(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (50) @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rst sout", 32'(SOUT), 1);
        chk("rst busy", 32'(BUSY), 0);
        @(negedge CLK);
        RST = 1'b0;
        watch_idle("after_rst", 40);
        push_frame(8'hC3, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        start_frame(8'hC3, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_frame("post_rst_C3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
